banked_byte_memory: RTL
=======================

// Module: banked_byte_memory
// PURPOSE
//   Parametrised successor of the unified instruction/data memory. Byte-addressed, little-endian,
//   N_RD registered read ports and one byte-masked write port. Unaligned word accesses complete
//   in one cycle via four byte-lane banks. Has a reset-time clear sequencer with a ready flag.
//   Sits between the core's fetch/load/store stages and the rest of the design.
// PARAMETERS
//   DEPTH          1024  words per bank (power of 2); byte space = 4*DEPTH
//   N_RD           2     read ports (port 0 = instruction, port 1 = data fetch)
//   ADDR_W         32    byte-address width; upper bits above log2(4*DEPTH) ignored (wrap)
//   CLEAR_ON_RESET 1     1: zero all rows after reset; 0: keep contents, ready next cycle
// PORTS
//   clk        in   1             clock, all state on rising edge
//   rst        in   1             asynchronous, active-low reset
//   ready      out  1             memory accepting requests
//   rd_req     in   N_RD          per-port read request
//   rd_addr    in   N_RD*ADDR_W   per-port byte address, any alignment
//   rd_valid   out  N_RD          rd_data valid this cycle
//   rd_data    out  N_RD*32       bytes [addr+3..addr], byte at addr in [7:0]
//   wr_bytes   in   3             0 none, 1 byte, 2 half, 4 word; others illegal
//   wr_addr    in   ADDR_W        byte address of lowest written byte, any alignment
//   wr_data    in   32            write data; byte k goes to wr_addr+k
//   wr_err     out  1             one-cycle pulse: illegal wr_bytes seen while ready
// BEHAVIOUR
//   Reset (rst=0): ready=0, rd_valid=0, rd_data=0, wr_err=0, FSM->CLEAR (or READY if !CLEAR_ON_RESET).
//   FSM: CLEAR: row counter 0..DEPTH-1 writes 0 to all 4 lanes, one row/cycle; after the last row
//     -> READY, ready=1 the following cycle. READY: stays until reset.
//   Clear time: DEPTH cycles + 1. rst low mid-clear restarts at row 0. With !CLEAR_ON_RESET, ready=1
//     on the first edge after rst release.
//   Lane mapping: byte address a -> lane a[1:0], row (a>>2) mod DEPTH. The access spans bytes
//     a..a+3 mod 4*DEPTH. Top-of-memory crossing wraps to byte 0.
//   Read: rd_req[i]&ready at edge N -> rd_valid[i]=1, rd_data[i] at edge N+1 (latency 1, no stall).
//     rd_data holds its last value when rd_valid=0. Requests while ready=0 are dropped.
//   Write: committed at the edge where ready=1 and wr_bytes in {1,2,4}. Only the addressed bytes
//     change. wr_bytes=0 is a no-op. Illegal values: no write, wr_err=1 next cycle.
//     Writes while ready=0 are ignored, no error.
//   Read and write in the same cycle on overlapping bytes: see CONFIGURATION. Two read ports may
//     hit the same bytes freely.
// CONFIGURATION
//   MEM_FWD_EN defined: write-to-read bypass. Overlapping bytes return the new wr_data bytes,
//     merged per byte; non-overlapping bytes come from the array.
//   MEM_FWD_EN undefined: read-before-write. All bytes return the pre-write contents.
// STRUCTURE
//   Package mem_pkg: wr_size_e enum (SZ_NONE=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=4);
//     mem_state_e (CLEAR, READY); function lane_row(addr, lane) giving the row for a lane;
//     function byte_mask(wr_bytes, addr[1:0]) giving the 4-bit lane enables.
//   Sub-module byte_lane_ram: one 8-bit x DEPTH bank, 1 write port, N_RD registered read ports.
//     Instantiated 4x. Top holds FSM, lane rotation, wrap logic, forwarding mux.
// TESTING
//   1 Reset, DEPTH=16: ready low exactly 17 cycles. Pre-load 0xFFFF_FFFF at 0x10, then re-reset:
//     read 0x10 -> 0x0000_0000. Pulse rst low at row 8 -> clear restarts, ready after a full 17.
//   2 Write 0xFFFF_FFFF word @0x100, then wr_bytes=1 data 0 -> read 0x100 = 0xFFFF_FF00.
//     wr_bytes=2 -> 0xFFFF_0000. wr_bytes=0 -> unchanged.
//   3 Word 0 @0x100 and @0x104. Write 0xAABB_CCDD word @0x101 -> read 0x100 = 0xBBCC_DD00,
//     read 0x104 = 0x0000_00AA, read 0x101 = 0xAABB_CCDD (unaligned read, port 0 and port 1 together).
//   4 Wrap, DEPTH=16: write 0x1122_3344 @0x3E -> read 0x3C = 0x3344_xxxx (bytes 0x3E, 0x3F),
//     read 0x00 low half = 0x1122.
//   5 wr_bytes=3 @0x200 with 0xDEAD_BEEF -> wr_err pulses 1 cycle, read 0x200 unchanged.
//     Reads requested during CLEAR -> rd_valid stays 0.
//   6 Same-cycle read and write @0x104 (old 0xDEAD_BEEF, write half 0xB0BA_CAFE) -> read
//     0xDEAD_CAFE with MEM_FWD_EN, 0xDEAD_BEEF without. Next read = 0xDEAD_CAFE in both builds.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and byte-lane address helpers for banked_byte_memory.
// Rows are returned unmasked; callers truncate to their bank depth (power of 2 gives the wrap).
package mem_pkg;

   typedef enum logic [2:0] {
      SZ_NONE = 3'd0,
      SZ_BYTE = 3'd1,
      SZ_HALF = 3'd2,
      SZ_WORD = 3'd4
   } wr_size_e;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_e;

   localparam int unsigned LANES = 4;

   // Lanes below the start offset hold the bytes that spill into the next row.
   function automatic logic [29:0] lane_row(input logic [31:0] addr, input logic [1:0] lane);
      return addr[31:2] + 30'(lane < addr[1:0]);
   endfunction

   function automatic logic [3:0] byte_mask(input logic [2:0] wr_bytes, input logic [1:0] off);
      logic [3:0] m;
      logic [7:0] r;
      case (wr_bytes)
         SZ_BYTE: m = 4'b0001;
         SZ_HALF: m = 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      r = {4'b0000, m} << off;
      return r[3:0] | r[7:4];
   endfunction

   function automatic logic wr_legal(input logic [2:0] wr_bytes);
      return (wr_bytes == SZ_BYTE) || (wr_bytes == SZ_HALF) || (wr_bytes == SZ_WORD);
   endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// One 8-bit bank: single write port, N_RD registered read ports (read-before-write).
module byte_lane_ram #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned N_RD  = 2,
   parameter int unsigned ROW_W = $clog2(DEPTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    we_i,
   input  logic [ROW_W-1:0]        waddr_i,
   input  logic [7:0]              wdata_i,
   input  logic [N_RD-1:0]         re_i,
   input  logic [N_RD*ROW_W-1:0]   raddr_i,
   output logic [N_RD*8-1:0]       rdata_o
);

   logic [7:0]        mem_q [DEPTH];
   logic [N_RD*8-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Output registers hold their value between reads.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         for (int i = 0; i < N_RD; i++) begin
            if (re_i[i]) rdata_q[i*8 +: 8] <= mem_q[raddr_i[i*ROW_W +: ROW_W]];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_byte_memory.sv
// Byte-addressed little-endian memory over four byte-lane banks with a reset-time clear sequencer.
// Define MEM_FWD_EN for write-to-read bypass; otherwise same-cycle reads see pre-write contents.
module banked_byte_memory
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH          = 1024,
   parameter int unsigned N_RD           = 2,
   parameter int unsigned ADDR_W         = 32,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   output logic                     ready_o,
   input  logic [N_RD-1:0]          rd_req_i,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
   output logic [N_RD-1:0]          rd_valid_o,
   output logic [N_RD*32-1:0]       rd_data_o,
   input  logic [2:0]               wr_bytes_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [31:0]              wr_data_i,
   output logic                     wr_err_o
);

   localparam int unsigned ROW_W   = $clog2(DEPTH);
   localparam int unsigned BYTE_AW = ROW_W + 2;

   mem_state_e           state_q, state_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic                 ready_q;
   logic [N_RD-1:0]      rd_valid_q;
   logic [N_RD*2-1:0]    off_q;
   logic                 wr_err_q;

   logic [N_RD-1:0]      rd_acc;
   logic [BYTE_AW-1:0]   wa;
   logic                 wr_fire;
   logic [3:0]           wmask;
   logic                 unused_addr_bits;

   logic [LANES-1:0]     bank_we;
   logic [ROW_W-1:0]     bank_waddr [LANES];
   logic [7:0]           bank_wdata [LANES];
   logic [N_RD*ROW_W-1:0] bank_raddr [LANES];
   logic [N_RD*8-1:0]    bank_rdata [LANES];

   // Address bits above the byte space are ignored so accesses wrap.
   assign unused_addr_bits = ^{wr_addr_i, rd_addr_i};

   assign wa      = wr_addr_i[BYTE_AW-1:0];
   assign wr_fire = ready_q && wr_legal(wr_bytes_i);
   assign wmask   = byte_mask(wr_bytes_i, wa[1:0]);
   assign rd_acc  = rd_req_i & {N_RD{ready_q}};

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      if (state_q == CLEAR) begin
         row_d = row_q + ROW_W'(1);
         if (row_q == ROW_W'(DEPTH - 1)) state_d = READY;
      end
   end

   // Write lanes: the clear sequencer owns every lane until the sweep is done.
   always_comb begin
      logic [1:0] k;
      k = '0;
      for (int l = 0; l < LANES; l++) begin
         k = 2'(l) - wa[1:0];
         if (state_q == CLEAR) begin
            bank_we[l]    = 1'b1;
            bank_waddr[l] = row_q;
            bank_wdata[l] = 8'h00;
         end else begin
            bank_we[l]    = wr_fire && wmask[l];
            bank_waddr[l] = ROW_W'(lane_row(32'(wa), 2'(l)));
            bank_wdata[l] = wr_data_i[8*k +: 8];
         end
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         bank_raddr[l] = '0;
         for (int i = 0; i < N_RD; i++) begin
            bank_raddr[l][i*ROW_W +: ROW_W] =
               ROW_W'(lane_row(32'(rd_addr_i[i*ADDR_W +: BYTE_AW]), 2'(l)));
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      byte_lane_ram #(
         .DEPTH (DEPTH),
         .N_RD  (N_RD),
         .ROW_W (ROW_W)
      ) u_bank (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .we_i    (bank_we[g]),
         .waddr_i (bank_waddr[g]),
         .wdata_i (bank_wdata[g]),
         .re_i    (rd_acc),
         .raddr_i (bank_raddr[g]),
         .rdata_o (bank_rdata[g])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         if (CLEAR_ON_RESET) state_q <= CLEAR;
         else                state_q <= READY;
         row_q      <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= '0;
         off_q      <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         ready_q    <= (state_q == READY);
         rd_valid_q <= rd_acc;
         for (int i = 0; i < N_RD; i++) begin
            if (rd_acc[i]) off_q[2*i +: 2] <= rd_addr_i[i*ADDR_W +: 2];
         end
         wr_err_q   <= ready_q && !wr_legal(wr_bytes_i) && (wr_bytes_i != SZ_NONE);
      end
   end

`ifdef MEM_FWD_EN
   logic [N_RD*LANES-1:0] fwd_hit_q;
   logic [N_RD*32-1:0]    fwd_data_q;

   // A lane hit means the same byte address is written in the read's cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fwd_hit_q  <= '0;
         fwd_data_q <= '0;
      end else begin
         for (int i = 0; i < N_RD; i++) begin
            for (int l = 0; l < LANES; l++) begin
               if (rd_acc[i]) begin
                  fwd_hit_q[i*LANES + l]   <= bank_we[l] &&
                     (bank_waddr[l] == bank_raddr[l][i*ROW_W +: ROW_W]);
                  fwd_data_q[i*32 + 8*l +: 8] <= bank_wdata[l];
               end
            end
         end
      end
   end
`endif

   // Rotate lanes back into address order; byte at the read address lands in [7:0].
   always_comb begin
      logic [1:0] lane;
      logic [7:0] b;
      lane      = '0;
      b         = '0;
      rd_data_o = '0;
      for (int i = 0; i < N_RD; i++) begin
         for (int k = 0; k < LANES; k++) begin
            lane = off_q[2*i +: 2] + 2'(k);
            b    = bank_rdata[lane][i*8 +: 8];
`ifdef MEM_FWD_EN
            if (fwd_hit_q[i*LANES + 32'(lane)]) b = fwd_data_q[i*32 + 8*32'(lane) +: 8];
`endif
            rd_data_o[i*32 + 8*k +: 8] = b;
         end
      end
   end

   assign ready_o    = ready_q;
   assign rd_valid_o = rd_valid_q;
   assign wr_err_o   = wr_err_q;

endmodule
